// File: rtl/ex_branch_resolve.sv
// rtl/ex_branch_resolve.sv - EX-stage branch/jump resolution, redirect, predictor training and counters
//
// Purpose:
//   Resolves conditional branches, JAL and JALR in the EX stage, compares the
//   actual outcome with the gshare direction prediction, and on a mispredict
//   issues a registered one-cycle redirect/flush. Every resolved conditional
//   branch produces a registered one-cycle training packet for the predictor.
//   After a redirect the instruction occupying EX came from the wrong path, so
//   it is squashed for one cycle (SHADOW state). Two saturating counters track
//   resolved conditional branches and mispredicts of all kinds.
//
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_stall                         EX held; the instruction does not retire
//   i_valid                         EX instruction valid
//   i_pc, i_rs1_data, i_rs2_data    PC and forwarded operands
//   i_imm                           sign-extended immediate
//   i_funct3                        branch condition code
//   i_is_branch/i_is_jal/i_is_jalr  control-flow class (jalr > jal > branch)
//   i_pred_taken                    gshare direction prediction
//   o_redirect_valid, o_redirect_pc fetch restart pulse and target
//   o_flush                         flush IF/ID and ID/EX (mirrors redirect)
//   o_kill_ex                       EX instruction is wrong-path
//   o_bp_upd_valid/pc/taken         predictor training packet
//   o_branch_cnt, o_mispred_cnt     saturating performance counters

module ex_branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_valid,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [2:0]       i_funct3,
    input  logic             i_is_branch,
    input  logic             i_is_jal,
    input  logic             i_is_jalr,
    input  logic             i_pred_taken,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush,
    output logic             o_kill_ex,
    output logic             o_bp_upd_valid,
    output logic [XLEN-1:0]  o_bp_upd_pc,
    output logic             o_bp_upd_taken,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    localparam logic [XLEN-1:0]  C_FOUR    = XLEN'(4);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_bp_upd_valid;
    logic [XLEN-1:0] r_bp_upd_pc;
    logic            r_bp_upd_taken;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic            w_squash;
    logic            w_rv;
    logic            w_sel_jalr;
    logic            w_sel_jal;
    logic            w_sel_branch;
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_cond_taken;
    logic [XLEN-1:0] w_pc_target;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_fall_through;
    logic            w_mispredict;
    logic [XLEN-1:0] w_correct_pc;
    logic            w_do_redirect;
    logic            w_do_train;

    // ------------------------------------------------------------------
    // Resolve qualification
    // ------------------------------------------------------------------
    // The instruction in EX during SHADOW was fetched before the redirect
    // took effect, so it must never resolve.
    assign w_squash = (r_state == ST_SHADOW);
    assign w_rv     = i_valid & ~i_stall & ~w_squash;

    // Exactly one class is acted upon when several flags are set.
    assign w_sel_jalr   = i_is_jalr;
    assign w_sel_jal    = i_is_jal & ~i_is_jalr;
    assign w_sel_branch = i_is_branch & ~i_is_jal & ~i_is_jalr;

    // ------------------------------------------------------------------
    // Branch condition evaluation
    // ------------------------------------------------------------------
    assign w_eq   = (i_rs1_data == i_rs2_data);
    assign w_lt_s = ($signed(i_rs1_data) < $signed(i_rs2_data));
    assign w_lt_u = (i_rs1_data < i_rs2_data);

    always_comb begin
        w_cond_taken = 1'b0;
        case (i_funct3)
            3'b000:  w_cond_taken = w_eq;
            3'b001:  w_cond_taken = ~w_eq;
            3'b100:  w_cond_taken = w_lt_s;
            3'b101:  w_cond_taken = ~w_lt_s;
            3'b110:  w_cond_taken = w_lt_u;
            3'b111:  w_cond_taken = ~w_lt_u;
            default: w_cond_taken = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

    // ------------------------------------------------------------------
    // Target computation
    // ------------------------------------------------------------------
    assign w_pc_target    = i_pc + i_imm;
    assign w_jalr_sum     = i_rs1_data + i_imm;
    assign w_jalr_target  = {w_jalr_sum[XLEN-1:1], 1'b0};
    assign w_fall_through = i_pc + C_FOUR;

    // JAL is redirected in ID already, so it can never mispredict here.
    // JALR has no target prediction, so it always redirects.
    always_comb begin
        w_mispredict = 1'b0;
        w_correct_pc = w_fall_through;
        if (w_sel_jalr) begin
            w_mispredict = 1'b1;
            w_correct_pc = w_jalr_target;
        end else if (w_sel_branch) begin
            w_mispredict = (w_cond_taken != i_pred_taken);
            w_correct_pc = w_cond_taken ? w_pc_target : w_fall_through;
        end
    end

    assign w_do_redirect = w_rv & w_mispredict;
    assign w_do_train    = w_rv & w_sel_branch;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_do_redirect) w_state_nxt = ST_SHADOW;
            // The shadow covers exactly one wrong-path slot, even if EX stalls.
            ST_SHADOW: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Redirect and training registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_do_redirect;
            if (w_do_redirect) begin
                r_redirect_pc <= w_correct_pc;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bp_upd_valid <= 1'b0;
            r_bp_upd_pc    <= '0;
            r_bp_upd_taken <= 1'b0;
        end else begin
            r_bp_upd_valid <= w_do_train;
            if (w_do_train) begin
                r_bp_upd_pc    <= i_pc;
                r_bp_upd_taken <= w_cond_taken;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_do_train && (r_branch_cnt != C_CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + C_CNT_ONE;
            end
            if (w_do_redirect && (r_mispred_cnt != C_CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + C_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = r_redirect_valid;
    assign o_kill_ex        = w_squash;
    assign o_bp_upd_valid   = r_bp_upd_valid;
    assign o_bp_upd_pc      = r_bp_upd_pc;
    assign o_bp_upd_taken   = r_bp_upd_taken;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb/tb_ex_branch_resolve.sv - directed self-checking bench for ex_branch_resolve

module tb_ex_branch_resolve;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  imm;
    logic [2:0]       funct3;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             pred_taken;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             kill_ex;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    ex_branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_stall          (stall),
        .i_valid          (valid),
        .i_pc             (pc),
        .i_rs1_data       (rs1),
        .i_rs2_data       (rs2),
        .i_imm            (imm),
        .i_funct3         (funct3),
        .i_is_branch      (is_branch),
        .i_is_jal         (is_jal),
        .i_is_jalr        (is_jalr),
        .i_pred_taken     (pred_taken),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_kill_ex        (kill_ex),
        .o_bp_upd_valid   (upd_valid),
        .o_bp_upd_pc      (upd_pc),
        .o_bp_upd_taken   (upd_taken),
        .o_branch_cnt     (branch_cnt),
        .o_mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = 1'b0; stall = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        pred_taken = 1'b0; funct3 = 3'b000; pc = '0; rs1 = '0; rs2 = '0; imm = '0;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic pt);
        idle_in();
        valid = 1'b1; is_branch = 1'b1; funct3 = f3; pc = p; rs1 = a; rs2 = b; imm = im;
        pred_taken = pt;
    endtask

    task automatic chk_cnt(input string tag, input int b, input int m);
        chk({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(b));
        chk({tag, "_mispred_cnt"}, 32'(mispred_cnt), 32'(m));
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_kill", 32'(kill_ex), 32'd0);
        chk("rst_upd", 32'(upd_valid), 32'd0);
        chk_cnt("rst", 0, 0);
        rst = 1'b0;
        tick();

        // 1. BEQ taken, predicted not taken
        br(3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0);
        tick();
        chk("beq_redirect", 32'(redirect_valid), 32'd1);
        chk("beq_flush", 32'(flush), 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        chk("beq_upd_valid", 32'(upd_valid), 32'd1);
        chk("beq_upd_pc", upd_pc, 32'h100);
        chk("beq_upd_taken", 32'(upd_taken), 32'd1);
        chk("beq_kill", 32'(kill_ex), 32'd1);
        chk_cnt("beq", 1, 1);
        idle_in();
        tick();
        chk("beq_pulse_redirect", 32'(redirect_valid), 32'd0);
        chk("beq_pulse_upd", 32'(upd_valid), 32'd0);
        chk("beq_kill_clear", 32'(kill_ex), 32'd0);

        // 2. BLT signed taken, predicted taken; then BLTU not taken, predicted taken
        br(3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        tick();
        chk("blt_redirect", 32'(redirect_valid), 32'd0);
        chk("blt_upd_valid", 32'(upd_valid), 32'd1);
        chk("blt_upd_taken", 32'(upd_taken), 32'd1);
        chk_cnt("blt", 2, 1);
        br(3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1);
        tick();
        chk("bltu_redirect", 32'(redirect_valid), 32'd1);
        chk("bltu_redirect_pc", redirect_pc, 32'h204);
        chk("bltu_upd_taken", 32'(upd_taken), 32'd0);
        chk_cnt("bltu", 3, 2);
        idle_in();
        tick();

        // 3. JALR clears bit 0; JAL never redirects nor trains
        idle_in();
        valid = 1'b1; is_jalr = 1'b1; pc = 32'h300; rs1 = 32'h2001; imm = 32'd4;
        tick();
        chk("jalr_redirect", 32'(redirect_valid), 32'd1);
        chk("jalr_redirect_pc", redirect_pc, 32'h2004);
        chk("jalr_upd", 32'(upd_valid), 32'd0);
        chk_cnt("jalr", 3, 3);
        idle_in();
        tick();
        idle_in();
        valid = 1'b1; is_jal = 1'b1; pc = 32'h400; imm = 32'd8;
        tick();
        chk("jal_redirect", 32'(redirect_valid), 32'd0);
        chk("jal_upd", 32'(upd_valid), 32'd0);
        chk_cnt("jal", 3, 3);

        // Flag priority: jalr wins over branch
        idle_in();
        valid = 1'b1; is_jalr = 1'b1; is_branch = 1'b1; rs1 = 32'h51; imm = 32'h10;
        tick();
        chk("prio_redirect_pc", redirect_pc, 32'h60);
        chk("prio_upd", 32'(upd_valid), 32'd0);
        chk_cnt("prio", 3, 4);
        idle_in();
        tick();

        // 4. Mispredict followed by a would-be-mispredicting BNE in the shadow
        br(3'b000, 32'h500, 32'd1, 32'd2, 32'h80, 1'b1);
        tick();
        chk("sq_redirect", 32'(redirect_valid), 32'd1);
        chk("sq_redirect_pc", redirect_pc, 32'h504);
        chk_cnt("sq_first", 4, 5);
        br(3'b001, 32'h504, 32'd1, 32'd2, 32'h80, 1'b0);
        chk("sq_kill", 32'(kill_ex), 32'd1);
        tick();
        chk("sq_no_redirect", 32'(redirect_valid), 32'd0);
        chk("sq_no_upd", 32'(upd_valid), 32'd0);
        chk_cnt("sq_second", 4, 5);
        idle_in();
        tick();

        // 5. Stalled BNE resolves once on release
        br(3'b001, 32'h600, 32'd3, 32'd4, 32'h10, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_upd", 32'(upd_valid), 32'd0);
            chk("stall_branch_cnt", 32'(branch_cnt), 32'd4);
        end
        stall = 1'b0;
        tick();
        chk("rel_upd", 32'(upd_valid), 32'd1);
        chk("rel_upd_pc", upd_pc, 32'h600);
        chk("rel_redirect", 32'(redirect_valid), 32'd0);
        chk_cnt("rel", 5, 5);
        idle_in();
        tick();
        chk("rel_pulse_upd", 32'(upd_valid), 32'd0);
        chk_cnt("rel_after", 5, 5);

        // Reset in the middle of SHADOW
        br(3'b000, 32'h700, 32'd1, 32'd1, 32'h8, 1'b0);
        tick();
        chk("pre_rst_kill", 32'(kill_ex), 32'd1);
        idle_in();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_redirect", 32'(redirect_valid), 32'd0);
        chk("midrst_flush", 32'(flush), 32'd0);
        chk("midrst_kill", 32'(kill_ex), 32'd0);
        chk("midrst_upd", 32'(upd_valid), 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        chk_cnt("midrst", 0, 0);
        tick();
        rst = 1'b0;
        tick();

        // 6. Saturation at 2^CNT_W-1
        for (int i = 0; i < 15; i++) begin
            br(3'b000, 32'h800, 32'd1, 32'd1, 32'h4, 1'b0);
            tick();
            idle_in();
            tick();
        end
        chk_cnt("sat_full", 15, 15);
        br(3'b000, 32'h900, 32'd1, 32'd1, 32'h4, 1'b0);
        tick();
        chk("sat_redirect", 32'(redirect_valid), 32'd1);
        chk("sat_redirect_pc", redirect_pc, 32'h904);
        chk_cnt("sat_hold", 15, 15);
        idle_in();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
